// File: rtl/shape_pkg.sv
// Shared types for the shape editor: shape record, edit modes, FSM states, step helper.
// Field widths are sized for the default 800x600 screen and 12-bit colour.
package shape_pkg;

    localparam int INT_BITS = 11;
    localparam int TY_W     = 2;
    localparam int X_W      = 10;
    localparam int Y_W      = 10;
    localparam int SZ_W     = 8;
    localparam int ANG_W    = 9;
    localparam int COL_W    = 12;

    typedef struct packed {
        logic [TY_W-1:0]         ty;
        logic [X_W-1:0]          x;
        logic [Y_W-1:0]          y;
        logic [SZ_W-1:0]         size;
        logic signed [ANG_W-1:0] angle;
        logic [COL_W-1:0]        colour;
    } shape_t;

    localparam shape_t SHAPE_DEFAULT = '{
        ty: '0, x: 10'd400, y: 10'd300, size: 8'd10, angle: '0, colour: '0
    };

    typedef enum logic [1:0] {
        MODE_MOVE   = 2'd0,
        MODE_SHAPE  = 2'd1,
        MODE_LIST   = 2'd2,
        MODE_COLOUR = 2'd3
    } edit_mode_e;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Button snapshot taken at the frame strobe so APPLY sees stable inputs.
    typedef struct packed {
        edit_mode_e       mode;
        logic [1:0]       mag;
        logic             l_p;
        logic             r_p;
        logic             u_p;
        logic             d_p;
        logic             l_once;
        logic             r_once;
        logic             c_once;
        logic [COL_W-1:0] colour;
    } cmd_t;

    function automatic logic signed [INT_BITS:0] step_delta(input logic [1:0] mag);
        step_delta = (INT_BITS+1)'(1) << {mag, 1'b0};
    endfunction

endpackage

// File: rtl/sat_step.sv
// Bounded step: cur +/- delta, then clamped (wrap=0) or folded circularly (wrap=1) into lo..hi.
// Purely combinational, zero latency, no flow control.
module sat_step
    import shape_pkg::*;
#(
    parameter int W = INT_BITS + 1
) (
    input  logic                en,
    input  logic                dec,
    input  logic                wrap,
    input  logic signed [W-1:0] cur,
    input  logic signed [W-1:0] delta,
    input  logic signed [W-1:0] lo,
    input  logic signed [W-1:0] hi,
    output logic signed [W-1:0] nxt
);

    localparam logic signed [W-1:0] ONE = W'(1);

    logic signed [W-1:0] sum;
    logic signed [W-1:0] span;

    always_comb begin
        sum  = dec ? (cur - delta) : (cur + delta);
        span = hi - lo + ONE;
        nxt  = cur;
        if (en) begin
            // delta never exceeds the span, so a single fold is enough
            if (sum > hi) begin
                nxt = wrap ? (sum - span) : hi;
            end else if (sum < lo) begin
                nxt = wrap ? (sum + span) : lo;
            end else begin
                nxt = sum;
            end
        end
    end

endmodule

// File: rtl/shape_edit_ctrl.sv
// Frame-synchronised shape table editor; edits commit leaving APPLY (frame+1), done pulses at frame+2.
// Frames outside IDLE are dropped; SHAPE_EDIT_UNDO_EN adds a one-record undo shadow.
module shape_edit_ctrl
    import shape_pkg::*;
#(
    parameter int  MAXSHP   = 4,
    parameter int  NTYPES   = 4,
    parameter int  SCR_W    = 800,
    parameter int  SCR_H    = 600,
    parameter int  SIZE_MIN = 1,
    parameter int  SIZE_MAX = 255,
    parameter int  PIXLW    = 12,
    localparam int SELW     = $clog2(MAXSHP)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame,
    input  logic [1:0]               mode,
    input  logic                     l_p,
    input  logic                     r_p,
    input  logic                     u_p,
    input  logic                     d_p,
    input  logic                     l_once,
    input  logic                     r_once,
    input  logic                     c_once,
    input  logic [1:0]               mag,
    input  logic [PIXLW-1:0]         pick_color,
    input  logic                     undo_once,
    output shape_t [MAXSHP-1:0]      shapes,
    output logic [SELW:0]            count,
    output logic [SELW-1:0]          sel,
    output logic                     done
);

    localparam int W = INT_BITS + 1;

    localparam logic signed [W-1:0] ZERO   = '0;
    localparam logic signed [W-1:0] X_HI   = W'(SCR_W - 1);
    localparam logic signed [W-1:0] Y_HI   = W'(SCR_H - 1);
    localparam logic signed [W-1:0] SZ_LO  = W'(SIZE_MIN);
    localparam logic signed [W-1:0] SZ_HI  = W'(SIZE_MAX);
    localparam logic signed [W-1:0] ANG_LO = W'(-180);
    localparam logic signed [W-1:0] ANG_HI = W'(179);

    localparam logic [SELW:0]   CNT_ONE = (SELW+1)'(1);
    localparam logic [SELW:0]   CNT_MAX = (SELW+1)'(MAXSHP);
    localparam logic [TY_W-1:0] TY_LAST = TY_W'(NTYPES - 1);

    localparam shape_t SHAPE_INIT = '{
        ty: '0, x: X_W'(SCR_W / 2), y: Y_W'(SCR_H / 2), size: 8'd10, angle: '0, colour: '1
    };

    state_e              state_q, state_d;
    shape_t [MAXSHP-1:0] tbl_q, tbl_d;
    logic [SELW:0]       count_q, count_d;
    logic [SELW-1:0]     sel_q, sel_d;
    cmd_t                cmd_q, cmd_d;

    shape_t              cur, rec, wr_rec;
    logic                wr_en, edit_en;
    logic [SELW-1:0]     wr_idx, last_idx;

    logic signed [W-1:0] delta, x_nxt, y_nxt, sz_nxt, ang_nxt;

`ifdef SHAPE_EDIT_UNDO_EN
    shape_t          sh_rec_q, sh_rec_d;
    logic [SELW-1:0] sh_idx_q, sh_idx_d;
    logic            sh_vld_q, sh_vld_d;
    logic            undo_q, undo_d;
    logic            undo_hit, rm_hit;
`else
    logic            unused_undo;
    assign unused_undo = undo_once;
`endif

    assign cur   = tbl_q[sel_q];
    assign delta = step_delta(cmd_q.mag);

    sat_step #(.W(W)) u_step_x (
        .en(cmd_q.l_p | cmd_q.r_p), .dec(cmd_q.l_p), .wrap(1'b0),
        .cur(W'(cur.x)), .delta(delta), .lo(ZERO), .hi(X_HI), .nxt(x_nxt)
    );

    sat_step #(.W(W)) u_step_y (
        .en(cmd_q.u_p | cmd_q.d_p), .dec(cmd_q.u_p), .wrap(1'b0),
        .cur(W'(cur.y)), .delta(delta), .lo(ZERO), .hi(Y_HI), .nxt(y_nxt)
    );

    sat_step #(.W(W)) u_step_size (
        .en(cmd_q.u_p | cmd_q.d_p), .dec(~cmd_q.u_p), .wrap(1'b0),
        .cur(W'(cur.size)), .delta(delta), .lo(SZ_LO), .hi(SZ_HI), .nxt(sz_nxt)
    );

    sat_step #(.W(W)) u_step_angle (
        .en(cmd_q.l_p | cmd_q.r_p), .dec(cmd_q.l_p), .wrap(1'b1),
        .cur({{(W-ANG_W){cur.angle[ANG_W-1]}}, cur.angle}),
        .delta(delta), .lo(ANG_LO), .hi(ANG_HI), .nxt(ang_nxt)
    );

    always_ff @(posedge clk) begin
        state_q <= state_d;
        tbl_q   <= tbl_d;
        count_q <= count_d;
        sel_q   <= sel_d;
        cmd_q   <= cmd_d;
    end

`ifdef SHAPE_EDIT_UNDO_EN
    always_ff @(posedge clk) begin
        sh_rec_q <= sh_rec_d;
        sh_idx_q <= sh_idx_d;
        sh_vld_q <= sh_vld_d;
        undo_q   <= undo_d;
    end
`endif

    always_comb begin
        state_d  = state_q;
        tbl_d    = tbl_q;
        count_d  = count_q;
        sel_d    = sel_q;
        cmd_d    = cmd_q;
        rec      = cur;
        wr_rec   = cur;
        wr_idx   = sel_q;
        wr_en    = 1'b0;
        edit_en  = 1'b1;
        last_idx = SELW'(count_q - 1'b1);
`ifdef SHAPE_EDIT_UNDO_EN
        sh_rec_d = sh_rec_q;
        sh_idx_d = sh_idx_q;
        sh_vld_d = sh_vld_q;
        undo_d   = undo_q;
        undo_hit = 1'b0;
        rm_hit   = 1'b0;
`endif

        case (state_q)
            ST_INIT: begin
                for (int i = 0; i < MAXSHP; i++) begin
                    tbl_d[i] = SHAPE_DEFAULT;
                end
                tbl_d[0] = SHAPE_INIT;
                count_d  = CNT_ONE;
                sel_d    = '0;
                state_d  = ST_DONE;
            end
            ST_IDLE: begin
                if (frame) begin
                    cmd_d.mode   = edit_mode_e'(mode);
                    cmd_d.mag    = mag;
                    cmd_d.l_p    = l_p;
                    cmd_d.r_p    = r_p;
                    cmd_d.u_p    = u_p;
                    cmd_d.d_p    = d_p;
                    cmd_d.l_once = l_once;
                    cmd_d.r_once = r_once;
                    cmd_d.c_once = c_once;
                    cmd_d.colour = COL_W'(pick_color);
`ifdef SHAPE_EDIT_UNDO_EN
                    undo_d       = undo_once;
`endif
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_DONE;
`ifdef SHAPE_EDIT_UNDO_EN
                undo_hit = undo_q && sh_vld_q && ({1'b0, sh_idx_q} < count_q);
                if (undo_hit) begin
                    wr_en   = 1'b1;
                    wr_idx  = sh_idx_q;
                    wr_rec  = sh_rec_q;
                    edit_en = 1'b0;
                end
`endif
                if (edit_en) begin
                    case (cmd_q.mode)
                        MODE_MOVE: begin
                            rec.x  = X_W'(x_nxt);
                            rec.y  = Y_W'(y_nxt);
                            wr_rec = rec;
                            wr_en  = 1'b1;
                        end
                        MODE_SHAPE: begin
                            rec.angle = ANG_W'(ang_nxt);
                            rec.size  = SZ_W'(sz_nxt);
                            if (cmd_q.c_once) begin
                                rec.ty = (rec.ty == TY_LAST) ? '0 : rec.ty + 1'b1;
                            end
                            wr_rec = rec;
                            wr_en  = 1'b1;
                        end
                        MODE_LIST: begin
                            if (cmd_q.l_once) begin
                                if (count_q > CNT_ONE) begin
                                    wr_en         = 1'b1;
                                    wr_idx        = last_idx;
                                    wr_rec        = tbl_q[last_idx];
                                    wr_rec.colour = '0;
                                    count_d       = count_q - 1'b1;
                                    if (sel_q == last_idx) begin
                                        sel_d = SELW'(count_q - 2'd2);
                                    end
`ifdef SHAPE_EDIT_UNDO_EN
                                    rm_hit        = 1'b1;
`endif
                                end
                            end else if (cmd_q.r_once) begin
                                if (count_q < CNT_MAX) begin
                                    wr_en   = 1'b1;
                                    wr_idx  = SELW'(count_q);
                                    wr_rec  = SHAPE_INIT;
                                    count_d = count_q + 1'b1;
                                    sel_d   = SELW'(count_q);
                                end
                            end else if (cmd_q.c_once) begin
                                sel_d = (sel_q == last_idx) ? '0 : sel_q + 1'b1;
                            end
                        end
                        MODE_COLOUR: begin
                            if (cmd_q.c_once) begin
                                rec.colour = cmd_q.colour;
                                wr_rec     = rec;
                                wr_en      = 1'b1;
                            end
                        end
                    endcase
                end

                if (wr_en) begin
                    tbl_d[wr_idx] = wr_rec;
                end

`ifdef SHAPE_EDIT_UNDO_EN
                // Restores and removals never refill the shadow; any other real change does.
                if (undo_hit) begin
                    sh_vld_d = 1'b0;
                end else if (rm_hit) begin
                    if (sh_idx_q == wr_idx) begin
                        sh_vld_d = 1'b0;
                    end
                end else if (wr_en && (wr_rec != tbl_q[wr_idx])) begin
                    sh_rec_d = tbl_q[wr_idx];
                    sh_idx_d = wr_idx;
                    sh_vld_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset discards any in-flight commit so the table is never half-edited.
        if (rst) begin
            state_d  = ST_INIT;
            tbl_d    = tbl_q;
            count_d  = count_q;
            sel_d    = sel_q;
`ifdef SHAPE_EDIT_UNDO_EN
            sh_vld_d = 1'b0;
`endif
        end
    end

    assign shapes = tbl_q;
    assign count  = count_q;
    assign sel    = sel_q;
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_shape_edit_ctrl.sv
// Directed bench for shape_edit_ctrl; expected values are hand-computed constants.
module tb_shape_edit_ctrl;
    import shape_pkg::*;

    localparam logic [7:0] B_L  = 8'h80;
    localparam logic [7:0] B_R  = 8'h40;
    localparam logic [7:0] B_U  = 8'h20;
    localparam logic [7:0] B_D  = 8'h10;
    localparam logic [7:0] B_LO = 8'h08;
    localparam logic [7:0] B_RO = 8'h04;
    localparam logic [7:0] B_CO = 8'h02;
    localparam logic [7:0] B_UN = 8'h01;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame = 1'b0;
    logic [1:0]      mode = '0;
    logic            l_p = 1'b0, r_p = 1'b0, u_p = 1'b0, d_p = 1'b0;
    logic            l_once = 1'b0, r_once = 1'b0, c_once = 1'b0;
    logic [1:0]      mag = '0;
    logic [11:0]     pick_color = '0;
    logic            undo_once = 1'b0;
    shape_t [3:0]    shapes;
    logic [2:0]      count;
    logic [1:0]      sel;
    logic            done;

    int n_chk = 0;
    int n_bad = 0;

    shape_edit_ctrl dut (
        .clk(clk), .rst(rst), .frame(frame), .mode(mode),
        .l_p(l_p), .r_p(r_p), .u_p(u_p), .d_p(d_p),
        .l_once(l_once), .r_once(r_once), .c_once(c_once),
        .mag(mag), .pick_color(pick_color), .undo_once(undo_once),
        .shapes(shapes), .count(count), .sel(sel), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_btn(input logic [7:0] b);
        {l_p, r_p, u_p, d_p, l_once, r_once, c_once, undo_once} = b;
    endtask

    // One frame strobe; done must be low in APPLY and high exactly one cycle later.
    task automatic frame_op(input logic [1:0] m, input logic [1:0] mg, input logic [7:0] b,
                            input logic [11:0] col);
        @(negedge clk);
        mode = m; mag = mg; pick_color = col; set_btn(b); frame = 1'b1;
        @(negedge clk);
        frame = 1'b0; set_btn(8'h00);
        chk("done_in_apply", done, 0);
        @(negedge clk);
        chk("done_pulse", done, 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("done_after_init", done, 1);
        @(negedge clk);
        chk("done_idle", done, 0);
    endtask

    initial begin
        // 1: reset state and done timing
        do_reset();
        chk("rst_count", count, 1);
        chk("rst_sel", sel, 0);
        chk("rst_x", shapes[0].x, 400);
        chk("rst_y", shapes[0].y, 300);
        chk("rst_size", shapes[0].size, 10);
        chk("rst_colour", shapes[0].colour, 12'hFFF);
        chk("rst_colour1", shapes[1].colour, 0);
        frame_op(2'd0, 2'd0, 8'h00, 12'h0);
        chk("idle_frame_x", shapes[0].x, 400);

        // 2: move with saturation
        repeat (6) frame_op(2'd0, 2'd3, B_L, 12'h0);
        repeat (3) frame_op(2'd0, 2'd1, B_L, 12'h0);
        repeat (2) frame_op(2'd0, 2'd0, B_L, 12'h0);
        chk("x_at_2", shapes[0].x, 2);
        frame_op(2'd0, 2'd1, B_L, 12'h0);
        chk("x_sat_lo", shapes[0].x, 0);
        repeat (12) frame_op(2'd0, 2'd3, B_R, 12'h0);
        frame_op(2'd0, 2'd2, B_R, 12'h0);
        repeat (3) frame_op(2'd0, 2'd1, B_R, 12'h0);
        repeat (2) frame_op(2'd0, 2'd0, B_R, 12'h0);
        chk("x_at_798", shapes[0].x, 798);
        frame_op(2'd0, 2'd1, B_R, 12'h0);
        chk("x_sat_hi", shapes[0].x, 799);
        frame_op(2'd0, 2'd0, B_U | B_D, 12'h0);
        chk("y_up_prio", shapes[0].y, 299);

        // 3: angle wrap, size saturation, type wrap
        repeat (2) frame_op(2'd1, 2'd3, B_L, 12'h0);
        repeat (3) frame_op(2'd1, 2'd2, B_L, 12'h0);
        repeat (4) frame_op(2'd1, 2'd0, B_L, 12'h0);
        chk("ang_m180", $signed(shapes[0].angle), -180);
        frame_op(2'd1, 2'd0, B_L, 12'h0);
        chk("ang_wrap_lo", $signed(shapes[0].angle), 179);
        frame_op(2'd1, 2'd1, B_R, 12'h0);
        chk("ang_wrap_hi", $signed(shapes[0].angle), -177);
        repeat (4) frame_op(2'd1, 2'd3, B_U, 12'h0);
        frame_op(2'd1, 2'd0, B_U, 12'h0);
        chk("size_sat_hi", shapes[0].size, 255);
        repeat (4) frame_op(2'd1, 2'd3, B_D, 12'h0);
        chk("size_sat_lo", shapes[0].size, 1);
        repeat (3) frame_op(2'd1, 2'd0, B_CO, 12'h0);
        chk("ty_3", shapes[0].ty, 3);
        frame_op(2'd1, 2'd0, B_CO, 12'h0);
        chk("ty_wrap", shapes[0].ty, 0);
        chk("x_kept_mode1", shapes[0].x, 799);

        // 4: add/remove/select
        repeat (3) frame_op(2'd2, 2'd0, B_RO, 12'h0);
        chk("add_count", count, 4);
        chk("add_sel", sel, 3);
        chk("add_rec_x", shapes[1].x, 400);
        chk("add_rec_col3", shapes[3].colour, 12'hFFF);
        frame_op(2'd2, 2'd0, B_RO, 12'h0);
        chk("add_full_count", count, 4);
        chk("add_full_sel", sel, 3);
        frame_op(2'd2, 2'd0, B_LO | B_RO, 12'h0);
        chk("rm_count", count, 3);
        chk("rm_sel", sel, 2);
        chk("rm_colour3", shapes[3].colour, 0);
        frame_op(2'd2, 2'd0, B_CO, 12'h0);
        chk("sel_wrap", sel, 0);

        // 5: colour load, then reset during APPLY
        repeat (2) frame_op(2'd2, 2'd0, B_CO, 12'h0);
        chk("sel_2", sel, 2);
        frame_op(2'd3, 2'd0, B_CO, 12'h0F0);
        chk("colour2", shapes[2].colour, 12'h0F0);
        chk("colour0_kept", shapes[0].colour, 12'hFFF);
        chk("colour1_kept", shapes[1].colour, 12'hFFF);
        @(negedge clk);
        mode = 2'd0; mag = 2'd3; set_btn(B_R); frame = 1'b1;
        @(negedge clk);
        frame = 1'b0; set_btn(8'h00); rst = 1'b1;
        @(negedge clk);
        chk("rst_apply_nodone", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_apply_init_done", done, 1);
        @(negedge clk);
        chk("rst2_count", count, 1);
        chk("rst2_sel", sel, 0);
        chk("rst2_colour2", shapes[2].colour, 0);
        chk("rst2_x0", shapes[0].x, 400);
        chk("rst2_x2", shapes[2].x, 400);
        chk("rst2_angle", $signed(shapes[0].angle), 0);

        // 6: undo
        frame_op(2'd0, 2'd1, B_R, 12'h0);
        chk("undo_pre_x", shapes[0].x, 404);
        frame_op(2'd0, 2'd0, B_UN, 12'h0);
`ifdef SHAPE_EDIT_UNDO_EN
        chk("undo_x", shapes[0].x, 400);
`else
        chk("undo_x", shapes[0].x, 404);
`endif
        frame_op(2'd0, 2'd0, B_UN, 12'h0);
`ifdef SHAPE_EDIT_UNDO_EN
        chk("undo2_x", shapes[0].x, 400);
`else
        chk("undo2_x", shapes[0].x, 404);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
